// File: rtl/aibcr3_rxdig_modectl.sv
// Mode sequencer for one RX digital datapath: quiesce, switch irxen, settle, release reset, flush.
// Optional macro AIBCR3_RXDIG_MODECTL_STATS_EN adds the o_switch_cnt completed-sequence counter.
module aibcr3_rxdig_modectl #(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned FLUSH_CYC  = 3,
  parameter int unsigned CNT_W      = 4
) (
  input  logic       iclkin_dist,
  input  logic       irstb,
  input  logic       mode_req,
  input  logic [2:0] mode_sel,
  output logic       mode_ack,
  output logic       mode_err,
  output logic       busy,
  output logic       rx_ready,
  output logic [2:0] o_irxen,
  output logic       o_rstb
`ifdef AIBCR3_RXDIG_MODECTL_STATS_EN
  ,
  output logic [7:0] o_switch_cnt
`endif
);

  localparam logic [2:0] RXEN_DISABLE = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUIESCE,
    ST_SWITCH,
    ST_RELEASE,
    ST_READY
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       tgt_q, tgt_d;
  logic [2:0]       irxen_q, irxen_d;
  logic             rstb_q, rstb_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             err_pend_q, err_pend_d;
  logic             err_new;
  logic             accepting;
  logic             legal;

  assign accepting = (state_q == ST_IDLE) || (state_q == ST_READY);
  assign legal     = (mode_sel <= 3'b100);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    irxen_d    = irxen_q;
    rstb_d     = rstb_q;
    rdy_d      = rdy_q;
    busy_d     = busy_q;
    ack_d      = 1'b0;
    err_new    = 1'b0;
    err_d      = 1'b0;
    err_pend_d = 1'b0;

    if (mode_req && !accepting) begin
      err_new = 1'b1;
    end

    case (state_q)
      ST_IDLE, ST_READY: begin
        if (mode_req) begin
          if (!legal) begin
            err_new = 1'b1;
          end else if (mode_sel == irxen_q) begin
            ack_d = 1'b1;
          end else begin
            tgt_d   = mode_sel;
            state_d = ST_QUIESCE;
            rstb_d  = 1'b0;
            rdy_d   = 1'b0;
            busy_d  = 1'b1;
          end
        end
      end
      ST_QUIESCE: begin
        state_d = ST_SWITCH;
        irxen_d = tgt_q;
        cnt_d   = CNT_W'(SETTLE_CYC - 1);
      end
      ST_SWITCH: begin
        if (cnt_q == '0) begin
          if (tgt_q == RXEN_DISABLE) begin
            state_d = ST_READY;
            busy_d  = 1'b0;
            ack_d   = 1'b1;
          end else begin
            state_d = ST_RELEASE;
            rstb_d  = 1'b1;
            cnt_d   = CNT_W'(FLUSH_CYC - 1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (cnt_q == '0) begin
          state_d = ST_READY;
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A busy-strobe error landing on the completion ack is held back one cycle
    // so ack and err never pulse together.
    if (ack_d) begin
      err_pend_d = err_new | err_pend_q;
    end else begin
      err_d = err_new | err_pend_q;
    end
  end

  always_ff @(posedge iclkin_dist or negedge irstb) begin
    if (!irstb) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tgt_q      <= RXEN_DISABLE;
      irxen_q    <= RXEN_DISABLE;
      rstb_q     <= 1'b0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      irxen_q    <= irxen_d;
      rstb_q     <= rstb_d;
      rdy_q      <= rdy_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      err_pend_q <= err_pend_d;
    end
  end

  assign mode_ack = ack_q;
  assign mode_err = err_q;
  assign busy     = busy_q;
  assign rx_ready = rdy_q;
  assign o_irxen  = irxen_q;
  assign o_rstb   = rstb_q;

`ifdef AIBCR3_RXDIG_MODECTL_STATS_EN
  logic [7:0] stat_q;

  // Only acks raised while a sequence was running count; same-mode acks occur with busy low.
  always_ff @(posedge iclkin_dist or negedge irstb) begin
    if (!irstb) begin
      stat_q <= '0;
    end else if (ack_d && busy_q && (stat_q != 8'hFF)) begin
      stat_q <= stat_q + 8'd1;
    end
  end

  assign o_switch_cnt = stat_q;
`endif

endmodule
